// File: rtl/int_ctrl.sv
// int_ctrl
// Memory-mapped interrupt controller sitting in front of the CPU's INTin/INTnum
// inputs. External interrupt lines are synchronised, latched as pending (level
// or edge mode per source), masked, and arbitrated with the lowest index
// winning. The winner is presented as a registered request plus a cause code.
//
// Parameters:
//   N_SRC       number of interrupt sources (1..16)
//   CAUSE_BASE  cause code reported for source 0; source i reports CAUSE_BASE+i
//
// Ports:
//   clk     CPU clock, all state changes on the rising edge
//   rst     asynchronous active-low reset
//   irq     raw external interrupt lines, asynchronous to clk
//   sel     register port select
//   we      1 = write, 0 = read (qualified by sel)
//   addr    register index: 0 PENDING, 1 MASK, 2 EDGE, 3 STATUS
//   wdata   write data
//   rdata   combinational read data, 0 unless a read is selected
//   INTout  registered interrupt request to the CPU
//   INTnum  registered cause code to the CPU
module int_ctrl #(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] CAUSE_BASE = 32'h10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             INTout,
    output logic [31:0]      INTnum
);

    logic [N_SRC-1:0] s1;
    logic [N_SRC-1:0] s2;
    logic [N_SRC-1:0] s3;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edgeMode;
    logic [N_SRC-1:0] setVec;
    logic [N_SRC-1:0] clrVec;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] wrBits;
    logic [4:0]       id;
    logic             wrPend;
    logic             wrMask;
    logic             wrEdge;

    // Register-port write decode. Only the low N_SRC bits of wdata are
    // meaningful; higher bits have no storage behind them.
    assign wrBits = wdata[N_SRC-1:0];
    assign wrPend = sel & we & (addr == 2'd0);
    assign wrMask = sel & we & (addr == 2'd1);
    assign wrEdge = sel & we & (addr == 2'd2);

    // Two-flop synchroniser for the asynchronous lines, plus a third stage
    // holding the previous synchronised value so rising edges can be seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edge sources latch on a synchronised rising edge; level sources latch
    // every cycle the line is high. The clear comes from a write-1-to-clear
    // on PENDING.
    always_comb begin
        setVec = (edgeMode & s2 & ~s3) | (~edgeMode & s2);
        clrVec = wrPend ? wrBits : '0;
    end

    // Configuration and pending state. Set is applied after clear so a
    // simultaneous set wins, which keeps a held level source pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            mask     <= '0;
            edgeMode <= '0;
        end else begin
            pending <= (pending & ~clrVec) | setVec;
            if (wrMask) begin
                mask <= wrBits;
            end
            if (wrEdge) begin
                edgeMode <= wrBits;
            end
        end
    end

    // Priority pick among unmasked pending sources. Scanning downward lets
    // the lowest index overwrite any higher one, so it wins.
    always_comb begin
        cand = pending & mask;
        id   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                id = 5'(i);
            end
        end
    end

    // Request and cause code are re-evaluated every cycle, so the request
    // persists until software clears or masks the source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            INTout <= 1'b0;
            INTnum <= '0;
        end else begin
            INTout <= |cand;
            INTnum <= (|cand) ? (CAUSE_BASE + 32'(id)) : '0;
        end
    end

    // Side-effect-free combinational read mux, zero-extending each register.
    always_comb begin
        rdata = '0;
        if (sel && !we) begin
            case (addr)
                2'd0:    rdata = 32'(pending);
                2'd1:    rdata = 32'(mask);
                2'd2:    rdata = 32'(edgeMode);
                default: rdata = {INTout, 26'b0, id};
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl
// Self-checking bench for int_ctrl. A table of per-cycle vectors (inputs plus
// expected outputs) is replayed one clock at a time; expected values are
// pushed onto a scoreboard queue when each vector is driven and popped when
// the outputs are sampled on the following falling edge. Hand-written
// sequences cover power-on reset and an asynchronous reset mid-request.
module tb_int_ctrl;

    typedef struct {
        string       name;
        logic [7:0]  irq;
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expInt;
        logic [31:0] expNum;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        intOut;
        logic [31:0] intNum;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        INTout;
    logic [31:0] INTnum;

    vec_t vecs[$];
    exp_t scoreboard[$];
    int   vectorsApplied;
    int   miscompares;

    int_ctrl #(.N_SRC(8), .CAUSE_BASE(32'h10)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .INTout (INTout),
        .INTnum (INTnum)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input string n, input logic [7:0] i, input logic s,
                          input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ei, input logic [31:0] en);
        vec_t v;
        v.name = n; v.irq = i; v.sel = s; v.we = w; v.addr = a; v.wdata = d;
        v.expRdata = er; v.expInt = ei; v.expNum = en;
        vecs.push_back(v);
    endtask

    task automatic expect3(input string n, input logic [31:0] er, input logic ei,
                           input logic [31:0] en);
        exp_t e;
        e.name = n; e.rdata = er; e.intOut = ei; e.intNum = en;
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        irq   = v.irq;
        sel   = v.sel;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        expect3(v.name, v.expRdata, v.expInt, v.expNum);
    endtask

    task automatic checkOutput();
        exp_t e;
        vectorsApplied++;
        if (scoreboard.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard: got empty queue, want an expected entry");
            return;
        end
        e = scoreboard.pop_front();
        if (rdata !== e.rdata) begin
            miscompares++;
            $display("[TB] FAIL %s rdata: got %h, want %h", e.name, rdata, e.rdata);
        end
        if (INTout !== e.intOut) begin
            miscompares++;
            $display("[TB] FAIL %s INTout: got %b, want %b", e.name, INTout, e.intOut);
        end
        if (INTnum !== e.intNum) begin
            miscompares++;
            $display("[TB] FAIL %s INTnum: got %h, want %h", e.name, INTnum, e.intNum);
        end
    endtask

    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        rst   = 1'b0;
        irq   = '0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // Level source 0: 4-edge latency, STATUS, then W1C against a held line
        addVec("t1_wr_mask",     8'h01 & 8'h00, 1, 1, 2'd1, 32'h01, 32'h0, 0, 32'h0);
        addVec("t1_wr_edge",     8'h00, 1, 1, 2'd2, 32'h00, 32'h0, 0, 32'h0);
        addVec("t1_irq_e1",      8'h01, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t1_irq_e2",      8'h01, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t1_irq_e3",      8'h01, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t1_status",      8'h01, 1, 0, 2'd3, 32'h00, 32'h80000000, 1, 32'h10);
        addVec("t1_rd_pend",     8'h01, 1, 0, 2'd0, 32'h00, 32'h01, 1, 32'h10);
        addVec("t3_w1c_held",    8'h01, 1, 1, 2'd0, 32'h01, 32'h0, 1, 32'h10);
        addVec("t3_pend_kept",   8'h01, 1, 0, 2'd0, 32'h00, 32'h01, 1, 32'h10);
        addVec("t3_drop_a",      8'h00, 0, 0, 2'd0, 32'h00, 32'h0, 1, 32'h10);
        addVec("t3_drop_b",      8'h00, 0, 0, 2'd0, 32'h00, 32'h0, 1, 32'h10);
        addVec("t3_w1c",         8'h00, 1, 1, 2'd0, 32'h01, 32'h0, 1, 32'h10);
        addVec("t3_cleared",     8'h00, 1, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        // Edge source 3 with a two-cycle pulse
        addVec("t2_wr_edge",     8'h00, 1, 1, 2'd2, 32'h08, 32'h0, 0, 32'h0);
        addVec("t2_wr_mask",     8'h00, 1, 1, 2'd1, 32'h08, 32'h0, 0, 32'h0);
        addVec("t2_pulse_a",     8'h08, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t2_pulse_b",     8'h08, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t2_wait",        8'h00, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t2_rd_pend",     8'h00, 1, 0, 2'd0, 32'h00, 32'h08, 1, 32'h13);
        addVec("t2_w1c",         8'h00, 1, 1, 2'd0, 32'h08, 32'h0, 1, 32'h13);
        addVec("t2_low",         8'h00, 1, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t2_stay_low",    8'h00, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        // Simultaneous edge sources 5 and 2: lower index first
        addVec("t4_wr_edge",     8'h00, 1, 1, 2'd2, 32'h24, 32'h0, 0, 32'h0);
        addVec("t4_wr_mask",     8'h00, 1, 1, 2'd1, 32'hFF, 32'h0, 0, 32'h0);
        addVec("t4_pulse_a",     8'h24, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t4_pulse_b",     8'h24, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t4_wait",        8'h00, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t4_rd_pend",     8'h00, 1, 0, 2'd0, 32'h00, 32'h24, 1, 32'h12);
        addVec("t4_clr2",        8'h00, 1, 1, 2'd0, 32'h04, 32'h0, 1, 32'h12);
        addVec("t4_status5",     8'h00, 1, 0, 2'd3, 32'h00, 32'h80000005, 1, 32'h15);
        addVec("t4_clr5",        8'h00, 1, 1, 2'd0, 32'h20, 32'h0, 1, 32'h15);
        addVec("t4_idle",        8'h00, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        // Masked source 1 latches anyway, then unmasking raises the request
        addVec("t5_mask0",       8'h00, 1, 1, 2'd1, 32'h00, 32'h0, 0, 32'h0);
        addVec("t5_irq_e1",      8'h02, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t5_irq_e2",      8'h02, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t5_irq_e3",      8'h02, 0, 0, 2'd0, 32'h00, 32'h0, 0, 32'h0);
        addVec("t5_rd_pend",     8'h02, 1, 0, 2'd0, 32'h00, 32'h02, 0, 32'h0);
        addVec("t5_unmask",      8'h02, 1, 1, 2'd1, 32'h02, 32'h0, 0, 32'h0);
        addVec("t5_status1",     8'h02, 1, 0, 2'd3, 32'h00, 32'h80000001, 1, 32'h11);
        // Upper register bits, unselected writes and STATUS writes are ignored
        addVec("b_mask_all",     8'h02, 1, 1, 2'd1, 32'hFFFFFFFF, 32'h0, 1, 32'h11);
        addVec("b_rd_mask",      8'h02, 1, 0, 2'd1, 32'h00, 32'h000000FF, 1, 32'h11);
        addVec("b_unsel_wr",     8'h02, 0, 1, 2'd1, 32'h00, 32'h0, 1, 32'h11);
        addVec("b_rd_mask2",     8'h02, 1, 0, 2'd1, 32'h00, 32'h000000FF, 1, 32'h11);
        addVec("b_wr_status",    8'h02, 1, 1, 2'd3, 32'h00, 32'h0, 1, 32'h11);
        addVec("b_rd_status",    8'h02, 1, 0, 2'd3, 32'h00, 32'h80000001, 1, 32'h11);

        // Power-on reset: everything reads 0 while reset is held
        #12;
        expect3("por_outputs", 32'h0, 0, 32'h0);
        checkOutput();
        sel = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            expect3($sformatf("por_reg%0d", a), 32'h0, 0, 32'h0);
            checkOutput();
        end
        sel = 1'b0;
        addr = '0;

        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k]);
            @(posedge clk);
            @(negedge clk);
            checkOutput();
        end

        // Asynchronous reset between clock edges while INTout is high
        #2;
        rst = 1'b0;
        #1;
        sel = 1'b0;
        we  = 1'b0;
        #1;
        expect3("arst_outputs", 32'h0, 0, 32'h0);
        checkOutput();
        sel = 1'b1;
        for (int a = 0; a < 3; a++) begin
            addr = 2'(a);
            #1;
            expect3($sformatf("arst_reg%0d", a), 32'h0, 0, 32'h0);
            checkOutput();
        end
        sel = 1'b0;
        addr = '0;

        // After release, held irq[1] re-latches but stays masked
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
        end
        sel  = 1'b1;
        addr = 2'd0;
        #1;
        expect3("post_rst_pend", 32'h02, 0, 32'h0);
        checkOutput();
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
